// File: rtl/reaction_pkg.sv
// Shared types for the multi-round reaction game: FSM states and display selector codes.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    SCORE,
    RESULT
  } state_e;

  typedef enum logic [1:0] {
    DSEL_MSG   = 2'd0,
    DSEL_BLANK = 2'd1,
    DSEL_VAL   = 2'd2
  } dsel_e;

endpackage

// File: rtl/edge_detect.sv
// Per-bit rise/fall detector against a one-cycle-delayed copy of the input.
// Outputs are combinational from the live input, so the consumer's registers see the edge on the next clock.
module edge_detect #(
  parameter int unsigned W               = 1,
  parameter logic [W-1:0] RST_VAL        = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= RST_VAL;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Multi-round reaction game: random delay, one-hot target LED, scored response, per-game average and best.
// Every output is registered and reacts one clock after the input edge that causes it.
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned NUM_SW       = 10,
  parameter int unsigned N_ROUNDS     = 4,
  parameter int unsigned TIME_W       = 20,
  parameter int unsigned RAND_W       = 15,
  parameter int unsigned MIN_DELAY_MS = 500,
  parameter int unsigned TIMEOUT_MS   = 9999,
  parameter int unsigned PENALTY_MS   = 1000
) (
  input  logic                        clk,
  input  logic                        rst_btn,
  input  logic                        start_btn,
  input  logic                        tick_ms,
  input  logic [NUM_SW-1:0]           switch,
  input  logic [RAND_W-1:0]           rand_num,
  output logic [NUM_SW-1:0]           led,
  output logic [1:0]                  disp_sel,
  output logic [TIME_W-1:0]           disp_val,
  output logic                        disp_dp,
  output logic [$clog2(N_ROUNDS):0]   round_idx,
  output logic [TIME_W-1:0]           best_ms,
  output logic                        false_start
);

  localparam int unsigned LOG_R = $clog2(N_ROUNDS);
  localparam int unsigned SUM_W = TIME_W + LOG_R;
  localparam int unsigned TGT_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
  localparam logic [TIME_W-1:0] PEN      = TIME_W'(PENALTY_MS);
  localparam logic [TIME_W-1:0] TMO      = TIME_W'(TIMEOUT_MS);
  localparam logic [31:0]       T_MAX32  = 32'({TIME_W{1'b1}});
  localparam logic [LOG_R:0]    LAST_RND = (LOG_R + 1)'(N_ROUNDS - 1);

  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] a,
                                                input logic [TIME_W-1:0] b);
    logic [TIME_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[TIME_W] ? '1 : s[TIME_W-1:0];
  endfunction

  state_e              state_q, state_d;
  dsel_e               dsel_q, dsel_d;
  logic [TIME_W-1:0]   delay_q, delay_d, cnt_q, cnt_d, pen_q, pen_d;
  logic [TIME_W-1:0]   best_q, best_d, dval_q, dval_d;
  logic [TGT_W-1:0]    tgt_q, tgt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [LOG_R:0]      round_q, round_d;
  logic [NUM_SW-1:0]   led_q, led_d;
  logic                dp_q, dp_d, fs_q, fs_d;

  logic                start_press;
  logic                start_rise_unused;
  logic [NUM_SW-1:0]   sw_rise, sw_fall_unused, tgt_mask;
  logic [31:0]         dly_sum;
  logic                enter_arm, to_score, wrong_rise;
  logic [TIME_W-1:0]   score_val, pen_now, avg;

  edge_detect #(.W(1), .RST_VAL(1'b1)) u_start_ed (
    .clk(clk), .rst_n(rst_btn), .d_i(start_btn),
    .rise_o(start_rise_unused), .fall_o(start_press)
  );

  edge_detect #(.W(NUM_SW), .RST_VAL('0)) u_sw_ed (
    .clk(clk), .rst_n(rst_btn), .d_i(switch),
    .rise_o(sw_rise), .fall_o(sw_fall_unused)
  );

  assign dly_sum    = 32'(rand_num) + MIN_DELAY_MS;
  assign tgt_mask   = NUM_SW'(1) << tgt_q;
  assign wrong_rise = |(sw_rise & ~tgt_mask);

  always_comb begin
    state_d = state_q;  dsel_d = dsel_q;  delay_d = delay_q;  cnt_d = cnt_q;
    pen_d   = pen_q;    best_d = best_q;  dval_d  = dval_q;   tgt_d = tgt_q;
    sum_d   = sum_q;    round_d = round_q; led_d  = led_q;    dp_d  = dp_q;
    fs_d    = fs_q;
    enter_arm = 1'b0;
    to_score  = 1'b0;
    score_val = '0;
    pen_now   = pen_q;
    avg       = '0;

    case (state_q)
      IDLE: begin
        led_d = '0;
        if (switch[0]) begin
          dsel_d = DSEL_MSG;  dval_d = '0;      dp_d = 1'b0;
        end else begin
          dsel_d = DSEL_VAL;  dval_d = best_q;  dp_d = 1'b1;
        end
        if (start_press) begin
          round_d = '0;  sum_d = '0;  enter_arm = 1'b1;
        end
      end
      // Exit conditions are checked before the tick so a coincident tick is dropped.
      ARM: begin
        if (|sw_rise) begin
          fs_d = 1'b1;  to_score = 1'b1;  score_val = PEN;
        end else if (start_press) begin
          enter_arm = 1'b1;
        end else if (cnt_q == delay_q) begin
          state_d = WAIT;  cnt_d = '0;  led_d = tgt_mask;
        end else if (tick_ms) begin
          cnt_d = cnt_q + TIME_W'(1);
        end
      end
      WAIT: begin
        if (wrong_rise) pen_now = sat_add(pen_q, PEN);
        pen_d = pen_now;
        if (sw_rise[tgt_q]) begin
          to_score = 1'b1;  score_val = sat_add(cnt_q, pen_now);
        end else if (cnt_q == TMO) begin
          to_score = 1'b1;  score_val = TMO;
        end else if (tick_ms) begin
          cnt_d = cnt_q + TIME_W'(1);
        end
      end
      // disp_val still holds the round score latched on entry.
      SCORE: begin
        sum_d = sum_q + SUM_W'(dval_q);
        if (round_q == LAST_RND) begin
          avg     = TIME_W'(sum_d >> LOG_R);
          state_d = RESULT;  dval_d = avg;  dsel_d = DSEL_VAL;  dp_d = 1'b1;
          if (avg < best_q) best_d = avg;
        end else begin
          round_d   = round_q + (LOG_R + 1)'(1);
          enter_arm = 1'b1;
        end
      end
      RESULT: begin
        if (start_press) begin
          round_d = '0;  sum_d = '0;  enter_arm = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (to_score) begin
      state_d = SCORE;  dval_d = score_val;  dsel_d = DSEL_VAL;  dp_d = 1'b1;  led_d = '0;
    end

    if (enter_arm) begin
      state_d = ARM;
      delay_d = (dly_sum > T_MAX32) ? '1 : TIME_W'(dly_sum);
      tgt_d   = TGT_W'(rand_num % RAND_W'(NUM_SW));
      cnt_d   = '0;  pen_d = '0;  fs_d = 1'b0;
      led_d   = '0;  dsel_d = DSEL_BLANK;  dp_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q <= IDLE;      dsel_q <= DSEL_MSG;  delay_q <= '0;  cnt_q <= '0;
      pen_q   <= '0;        best_q <= '1;        dval_q  <= '0;  tgt_q <= '0;
      sum_q   <= '0;        round_q <= '0;       led_q   <= '0;  dp_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;   dsel_q <= dsel_d;    delay_q <= delay_d;  cnt_q <= cnt_d;
      pen_q   <= pen_d;     best_q <= best_d;    dval_q  <= dval_d;   tgt_q <= tgt_d;
      sum_q   <= sum_d;     round_q <= round_d;  led_q   <= led_d;    dp_q  <= dp_d;
      fs_q    <= fs_d;
    end
  end

  assign led         = led_q;
  assign disp_sel    = dsel_q;
  assign disp_val    = dval_q;
  assign disp_dp     = dp_q;
  assign round_idx   = round_q;
  assign best_ms     = best_q;
  assign false_start = fs_q;

endmodule
